// File: rtl/dual_debounce_tick_if.sv
// Button-side signal bundle for dual_debounce_tick: raw switch inputs in,
// debounced levels, rising-edge ticks and state visibility out.
interface dual_debounce_tick_if;
  logic       sw_a;
  logic       sw_b;
  logic       db_a;
  logic       db_b;
  logic       a_tick;
  logic       b_tick;
  logic [1:0] state_a_tb;
  logic [1:0] state_b_tb;

  modport master (
    output sw_a, sw_b,
    input  db_a, db_b, a_tick, b_tick, state_a_tb, state_b_tb
  );

  modport slave (
    input  sw_a, sw_b,
    output db_a, db_b, a_tick, b_tick, state_a_tb, state_b_tb
  );
endinterface

// File: rtl/dual_debounce_tick.sv
// Two independent button debouncers: 2-FF synchronizer, stable-count FSM,
// debounced level and a one-clock tick on each debounced press.
module dual_debounce_tick_chan #(
  parameter int DB_CYCLES = 8,
  parameter int CNT_W     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw,
  output logic       db,
  output logic       tick,
  output logic [1:0] state_tb
);
  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] LOAD = CNT_W'(DB_CYCLES - 1);

  logic             sync1;
  logic             s;
  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             tick_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
      state <= ZERO;
      cnt   <= '0;
      tick  <= 1'b0;
    end else begin
      sync1 <= sw;
      s     <= sync1;
      state <= state_nx;
      cnt   <= cnt_nx;
      tick  <= tick_nx;
    end
  end

  // Tick is registered alongside the state so it is high exactly while the
  // first cycle of ONE is visible.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    tick_nx  = 1'b0;
    case (state)
      ZERO: begin
        if (s) begin
          state_nx = WAIT1;
          cnt_nx   = LOAD;
        end
      end
      WAIT1: begin
        if (!s) begin
          state_nx = ZERO;
        end else if (cnt != '0) begin
          cnt_nx = cnt - CNT_W'(1);
        end else begin
          state_nx = ONE;
          tick_nx  = 1'b1;
        end
      end
      ONE: begin
        if (!s) begin
          state_nx = WAIT0;
          cnt_nx   = LOAD;
        end
      end
      WAIT0: begin
        if (s) begin
          state_nx = ONE;
        end else if (cnt != '0) begin
          cnt_nx = cnt - CNT_W'(1);
        end else begin
          state_nx = ZERO;
        end
      end
      default: state_nx = ZERO;
    endcase
  end

  assign db       = (state == ONE) || (state == WAIT0);
  assign state_tb = state;
endmodule

module dual_debounce_tick #(
  parameter int DB_CYCLES = 8,
  parameter int CNT_W     = 3
) (
  input logic                 clk,
  input logic                 reset,
  dual_debounce_tick_if.slave bus
);
  dual_debounce_tick_chan #(
    .DB_CYCLES(DB_CYCLES),
    .CNT_W    (CNT_W)
  ) u_chan_a (
    .clk     (clk),
    .reset   (reset),
    .sw      (bus.sw_a),
    .db      (bus.db_a),
    .tick    (bus.a_tick),
    .state_tb(bus.state_a_tb)
  );

  dual_debounce_tick_chan #(
    .DB_CYCLES(DB_CYCLES),
    .CNT_W    (CNT_W)
  ) u_chan_b (
    .clk     (clk),
    .reset   (reset),
    .sw      (bus.sw_b),
    .db      (bus.db_b),
    .tick    (bus.b_tick),
    .state_tb(bus.state_b_tb)
  );
endmodule

// File: tb/tb_dual_debounce_tick.sv
// Scoreboard bench for dual_debounce_tick: a stable-run reference model
// predicts every cycle's outputs; a monitor pops and compares them.
module tb_dual_debounce_tick;
  localparam int DB = 8;

  typedef struct packed {
    logic       db_a;
    logic       db_b;
    logic       a_tick;
    logic       b_tick;
    logic [1:0] st_a;
    logic [1:0] st_b;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dual_debounce_tick_if bus ();

  dual_debounce_tick #(
    .DB_CYCLES(DB),
    .CNT_W    (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_tick_a = 0;
  int n_tick_b = 0;
  int cycle = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cycle, act, req);
  endtask

  // Reference model: the debounced level flips once the synchronized input
  // (raw input delayed two clocks) has disagreed with it for DB+1 samples.
  logic m_s1[2];
  logic m_s2[2];
  logic m_db[2];
  logic m_tick[2];
  int   m_run[2];
  logic m_sw[2];
  exp_t m_e;

  always @(posedge clk) begin
    cycle++;
    m_sw[0] = bus.sw_a;
    m_sw[1] = bus.sw_b;
    for (int c = 0; c < 2; c++) begin
      if (!reset) begin
        m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_db[c] = 1'b0;
        m_tick[c] = 1'b0; m_run[c] = 0;
      end else begin
        m_tick[c] = 1'b0;
        if (m_s2[c] == m_db[c]) m_run[c] = 0;
        else begin
          m_run[c]++;
          if (m_run[c] == DB + 1) begin
            m_db[c]   = ~m_db[c];
            m_run[c]  = 0;
            m_tick[c] = m_db[c];
          end
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = m_sw[c];
      end
    end
    m_e.db_a   = m_db[0];
    m_e.db_b   = m_db[1];
    m_e.a_tick = m_tick[0];
    m_e.b_tick = m_tick[1];
    m_e.st_a   = {m_db[0], m_run[0] != 0};
    m_e.st_b   = {m_db[1], m_run[1] != 0};
    exp_q.push_back(m_e);
  end

  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (bus.a_tick) n_tick_a++;
    if (bus.b_tick) n_tick_b++;
    check("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("db_a",   32'(bus.db_a),       32'(mon_e.db_a));
      check("db_b",   32'(bus.db_b),       32'(mon_e.db_b));
      check("a_tick", 32'(bus.a_tick),     32'(mon_e.a_tick));
      check("b_tick", 32'(bus.b_tick),     32'(mon_e.b_tick));
      check("st_a",   32'(bus.state_a_tb), 32'(mon_e.st_a));
      check("st_b",   32'(bus.state_b_tb), 32'(mon_e.st_b));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cycle);
    $fatal(1, "watchdog expired");
  end

  int ta, tb_c, hold_a, hold_b, waited;
  initial begin
    bus.sw_a = 1'b1;
    bus.sw_b = 1'b1;
    // 1: reset with both buttons held, then release
    cyc(3);
    check("rst_outputs", 32'({bus.db_a, bus.db_b, bus.a_tick, bus.b_tick,
                              bus.state_a_tb, bus.state_b_tb}), 32'd0);
    ta = n_tick_a; tb_c = n_tick_b;
    reset = 1'b1;
    cyc(30);
    check("t1_ticks_a", 32'(n_tick_a - ta), 32'd1);
    check("t1_ticks_b", 32'(n_tick_b - tb_c), 32'd1);
    bus.sw_a = 1'b0; bus.sw_b = 1'b0;
    cyc(30);

    // 2: clean press held 40 clocks
    ta = n_tick_a; tb_c = n_tick_b;
    bus.sw_a = 1'b1; cyc(40);
    bus.sw_a = 1'b0; cyc(30);
    check("t2_ticks_a", 32'(n_tick_a - ta), 32'd1);
    check("t2_ticks_b", 32'(n_tick_b - tb_c), 32'd0);

    // 3: bouncing press
    ta = n_tick_a;
    bus.sw_a = 1'b1; cyc(3);
    bus.sw_a = 1'b0; cyc(2);
    bus.sw_a = 1'b1; cyc(5);
    bus.sw_a = 1'b0; cyc(1);
    bus.sw_a = 1'b1; cyc(30);
    check("t3_ticks_a", 32'(n_tick_a - ta), 32'd1);

    // 4: short release glitch while debounced high
    ta = n_tick_a;
    bus.sw_a = 1'b0; cyc(5);
    bus.sw_a = 1'b1; cyc(20);
    check("t4_ticks_a", 32'(n_tick_a - ta), 32'd0);
    check("t4_db_a", 32'(bus.db_a), 32'd1);
    bus.sw_a = 1'b0; cyc(30);

    // 5: simultaneous press, B released early
    ta = n_tick_a; tb_c = n_tick_b;
    bus.sw_a = 1'b1; bus.sw_b = 1'b1; cyc(20);
    check("t5_ticks_a", 32'(n_tick_a - ta), 32'd1);
    check("t5_ticks_b", 32'(n_tick_b - tb_c), 32'd1);
    bus.sw_b = 1'b0; cyc(30);
    check("t5_db_a_held", 32'(bus.db_a), 32'd1);
    check("t5_db_b_rel", 32'(bus.db_b), 32'd0);
    bus.sw_a = 1'b0; cyc(30);

    // 6: reset while A is in WAIT1 with cnt=3
    ta = n_tick_a;
    bus.sw_a = 1'b1;
    waited = 0;
    while (bus.state_a_tb != 2'b01 && waited < 12) begin
      cyc(1);
      waited++;
    end
    check("t6_reach_wait1", 32'(bus.state_a_tb), 32'd1);
    repeat (4) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("t6_rst_state", 32'(bus.state_a_tb), 32'd0);
    check("t6_rst_tick", 32'(bus.a_tick), 32'd0);
    cyc(2);
    reset = 1'b1;
    cyc(30);
    check("t6_ticks_a", 32'(n_tick_a - ta), 32'd1);
    bus.sw_a = 1'b0; cyc(30);

    // Randomized independent bouncing on both channels
    hold_a = 0; hold_b = 0;
    repeat (3000) begin
      @(negedge clk);
      if (hold_a == 0) begin
        bus.sw_a = ~bus.sw_a;
        hold_a = $urandom_range(24, 1);
      end
      if (hold_b == 0) begin
        bus.sw_b = ~bus.sw_b;
        hold_b = $urandom_range(24, 1);
      end
      hold_a--;
      hold_b--;
    end
    cyc(30);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
